// File: rtl/select_leaf_node.sv
// Leaf extraction for a 4-symbol Huffman tree: finds the two internal nodes by
// weight sums and registers the four remaining leaf records in index order.
module select_leaf_node (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [12:0] info_node_1,
   input  logic [12:0] info_node_2,
   input  logic [12:0] info_node_3,
   input  logic [12:0] info_node_4,
   input  logic [12:0] info_node_5,
   input  logic [12:0] info_node_6,
   input  logic [12:0] info_node_7,
   output logic [12:0] leaf_A,
   output logic [12:0] leaf_B,
   output logic [12:0] leaf_C,
   output logic [12:0] leaf_D
);

   logic [12:0] node [1:6];
   logic [8:0]  sum0;
   logic [8:0]  sum1;
   logic [6:1]  eq0;
   logic [6:1]  eq1;
   logic [6:1]  i0_mask;
   logic [6:1]  i1_mask;
   logic        i0_found;
   logic        i1_found;
   logic [6:1]  excl_mask;
   logic [12:0] leaf_next [0:3];
   logic [12:0] leaf_reg  [0:3];
   logic        unused_root;

   // The root record only closes the tree; it can never be a leaf.
   assign unused_root = ^info_node_7;

   assign node[1] = info_node_1;
   assign node[2] = info_node_2;
   assign node[3] = info_node_3;
   assign node[4] = info_node_4;
   assign node[5] = info_node_5;
   assign node[6] = info_node_6;

   // 9-bit sums so that an overflowing pair can never alias a small weight.
   assign sum0 = {1'b0, node[1][7:0]} + {1'b0, node[2][7:0]};
   assign sum1 = {1'b0, node[3][7:0]} + {1'b0, node[4][7:0]};

   generate
      for (genvar gi = 1; gi <= 6; gi++) begin : g_match
         if (gi >= 3) begin : g_eq0
            assign eq0[gi] = (sum0 == {1'b0, node[gi][7:0]});
         end else begin : g_no_eq0
            assign eq0[gi] = 1'b0;
         end
         if (gi >= 5) begin : g_eq1
            assign eq1[gi] = (sum1 == {1'b0, node[gi][7:0]});
         end else begin : g_no_eq1
            assign eq1[gi] = 1'b0;
         end
      end
   endgenerate

   // Lowest-index match wins; merge 1's product may not reuse merge 0's.
   always_comb begin
      i0_found = 1'b0;
      i0_mask  = '0;
      for (int j = 3; j <= 6; j++) begin
         if (!i0_found && eq0[j]) begin
            i0_found   = 1'b1;
            i0_mask[j] = 1'b1;
         end
      end
   end

   always_comb begin
      i1_found = 1'b0;
      i1_mask  = '0;
      for (int j = 5; j <= 6; j++) begin
         if (!i1_found && eq1[j] && !i0_mask[j]) begin
            i1_found   = 1'b1;
            i1_mask[j] = 1'b1;
         end
      end
   end

   // Fallback excludes nodes 5 and 6, which yields nodes 1..4 unchanged.
   assign excl_mask = (i0_found && i1_found) ? (i0_mask | i1_mask) : 6'b110000;

   always_comb begin
      logic [2:0] cnt;
      cnt = 3'd0;
      for (int k = 0; k < 4; k++) begin
         leaf_next[k] = '0;
      end
      for (int j = 1; j <= 6; j++) begin
         if (!excl_mask[j]) begin
            if (cnt < 3'd4) begin
               leaf_next[cnt[1:0]] = node[j];
            end
            cnt = cnt + 3'd1;
         end
      end
   end

   always_ff @(posedge CLK or posedge nRST) begin
      if (nRST) begin
         for (int k = 0; k < 4; k++) begin
            leaf_reg[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            leaf_reg[k] <= leaf_next[k];
         end
      end
   end

   assign leaf_A = leaf_reg[0];
   assign leaf_B = leaf_reg[1];
   assign leaf_C = leaf_reg[2];
   assign leaf_D = leaf_reg[3];

endmodule

// File: tb/tb_select_leaf_node.sv
// Self-checking bench for select_leaf_node: vector table driven through a
// scoreboard queue, plus reset and back-to-back sequences.
module tb_select_leaf_node;

   logic        CLK = 1'b0;
   logic        nRST = 1'b1;
   logic [12:0] info_node_1, info_node_2, info_node_3, info_node_4;
   logic [12:0] info_node_5, info_node_6, info_node_7;
   logic [12:0] leaf_A, leaf_B, leaf_C, leaf_D;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [90:0] n;   // {node7, ..., node1}
      logic [51:0] e;   // {A, B, C, D}
   } vec_t;

   vec_t        vecs [8];
   string       names [8];
   logic [51:0] exp_q [$];

   select_leaf_node dut (
      .CLK(CLK), .nRST(nRST),
      .info_node_1(info_node_1), .info_node_2(info_node_2),
      .info_node_3(info_node_3), .info_node_4(info_node_4),
      .info_node_5(info_node_5), .info_node_6(info_node_6),
      .info_node_7(info_node_7),
      .leaf_A(leaf_A), .leaf_B(leaf_B), .leaf_C(leaf_C), .leaf_D(leaf_D)
   );

   always #5 CLK = ~CLK;

   function automatic vec_t mk(input logic [12:0] n1, n2, n3, n4, n5, n6, n7,
                               input logic [12:0] a, b, c, d);
      vec_t v;
      v.n = {n7, n6, n5, n4, n3, n2, n1};
      v.e = {a, b, c, d};
      return v;
   endfunction

   task automatic check(input string name, input logic [51:0] req);
      logic [51:0] act;
      act = {leaf_A, leaf_B, leaf_C, leaf_D};
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got A=%h B=%h C=%h D=%h, want A=%h B=%h C=%h D=%h",
                  name, act[51:39], act[38:26], act[25:13], act[12:0],
                  req[51:39], req[38:26], req[25:13], req[12:0]);
      end else begin
         $display("ok   %s: A=%h B=%h C=%h D=%h", name,
                  act[51:39], act[38:26], act[25:13], act[12:0]);
      end
   endtask

   task automatic drive(input vec_t v);
      {info_node_7, info_node_6, info_node_5, info_node_4,
       info_node_3, info_node_2, info_node_1} = v.n;
   endtask

   // Drive one vector, expect its result after the next rising edge.
   task automatic step(input vec_t v, input string name);
      logic [51:0] req;
      drive(v);
      exp_q.push_back(v.e);
      @(posedge CLK);
      #1;
      req = exp_q.pop_front();
      check(name, req);
   endtask

   initial begin
      vecs[0] = mk(13'h01A, 13'h11C, 13'h222, 13'h32B, 13'h43D, 13'h544, 13'h1F77,
                   13'h01A, 13'h11C, 13'h222, 13'h32B);
      names[0] = "inconsistent";
      vecs[1] = mk(13'h005, 13'h107, 13'h209, 13'h30C, 13'h415, 13'h519, 13'h1F2E,
                   13'h005, 13'h107, 13'h209, 13'h519);
      names[1] = "i0_node4";
      vecs[2] = mk(13'h002, 13'h103, 13'h205, 13'h306, 13'h40A, 13'h50B, 13'h1F15,
                   13'h002, 13'h103, 13'h306, 13'h40A);
      names[2] = "i0_node3";
      vecs[3] = mk(13'h0C8, 13'h164, 13'h22C, 13'h30A, 13'h401, 13'h502, 13'h1F00,
                   13'h0C8, 13'h164, 13'h22C, 13'h30A);
      names[3] = "overflow";
      vecs[4] = mk(13'h001, 13'h102, 13'h203, 13'h303, 13'h406, 13'h50F, 13'h1F0F,
                   13'h001, 13'h102, 13'h303, 13'h50F);
      names[4] = "tie_lowest_i0";
      vecs[5] = mk(13'h001, 13'h102, 13'h205, 13'h303, 13'h407, 13'h508, 13'h1F0F,
                   13'h001, 13'h102, 13'h205, 13'h407);
      names[5] = "i0_node4_i1_node6";
      vecs[6] = mk(13'h001, 13'h102, 13'h203, 13'h304, 13'h408, 13'h509, 13'h1F0F,
                   13'h001, 13'h102, 13'h203, 13'h304);
      names[6] = "i1_missing";
      vecs[7] = mk(13'h104, 13'h005, 13'h202, 13'h307, 13'h409, 13'h509, 13'h1F12,
                   13'h104, 13'h005, 13'h202, 13'h307);
      names[7] = "shared_sum";

      // Reset held with live inputs and a running clock.
      drive(vecs[1]);
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK);
         #1;
         check("reset_hold", 52'd0);
      end

      // Release between edges; the next edge loads the current inputs.
      nRST = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(vecs[i], names[i]);
      end

      // Back-to-back alternation of the two valid trees.
      for (int i = 0; i < 6; i++) begin
         step(vecs[(i % 2 == 0) ? 1 : 2], "back_to_back");
      end

      // Mid-stream asynchronous reset: outputs must clear before any edge.
      #2;
      nRST = 1'b1;
      #1;
      check("async_reset", 52'd0);
      @(posedge CLK);
      #1;
      check("reset_held_edge", 52'd0);
      nRST = 1'b0;
      step(vecs[2], "after_reset");
      step(vecs[0], "after_reset_fallback");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/select_leaf_node.md
# select_leaf_node

Registered leaf-extraction stage of the Huffman tree builder. It takes the seven node records of a 4-symbol Huffman tree: six merged children plus the root. It identifies the two internal (merged) nodes by weight arithmetic and presents the four leaf records on `leaf_A`..`leaf_D`, ordered by ascending node index. The code-assignment stage downstream consumes these leaves.

## Interface
- No parameters. Record width is fixed at 13 bits.
- `CLK` input 1: sole clock; rising-edge active.
- `nRST` input 1: asynchronous reset, active-high. Asserting it high clears all outputs immediately.
- `info_node_1` .. `info_node_7` input 13 each: node records.
  - `[12:9]` merge step in which the node is consumed (0, 1 or 2; `4'hF` marks the root).
  - `[8]` branch bit.
  - `[7:0]` weight, unsigned.
- `leaf_A`, `leaf_B`, `leaf_C`, `leaf_D` output 13 each: selected leaf records, copied verbatim.

## Operation
- Nodes 1–2 are the children of merge 0, nodes 3–4 of merge 1, nodes 5–6 of merge 2. Node 7 is the root and is never a leaf. Fields `[12:9]` and `[8]` are passed through and never checked.
- Sums are 9-bit unsigned, so overflow never wraps. A sum matches a node only if it equals the node's weight zero-extended to 9 bits.
- I0 (product of merge 0):
  - S0 = w1 + w2.
  - I0 is the lowest-index node among 3..6 whose weight equals S0.
- I1 (product of merge 1):
  - S1 = w3 + w4.
  - I1 is the lowest-index node among 5..6, excluding I0, whose weight equals S1.
- Valid tree: both I0 and I1 are found.
  - Leaves are nodes {1..6} minus {I0, I1}, in ascending index order.
  - These four nodes map to A, B, C, D in that order.
- Fallback: if either I0 or I1 is not found, the outputs are A = node1, B = node2, C = node3, D = node4.
- All selection logic is combinational. Only the four outputs are registered.

## Timing
- Reset: while `nRST` is high, all four outputs are 13'h000, asynchronously and independent of `CLK`.
- After `nRST` falls, the first rising edge loads the result of the current inputs.
- Latency is one cycle:
  - Outputs at edge k+1 reflect the inputs sampled at edge k+1, computed from values stable before that edge.
  - No handshake; throughput is one selection per cycle.
- Inputs changing every cycle are legal. Each edge captures an independent result.
- Reset asserted mid-stream: outputs clear at once. The first edge after release produces a fresh result; no history is kept.
- Equal-weight ties are resolved by lowest index, as above. The result is deterministic for every input combination.

## Test plan
- Reset: hold `nRST`=1 with arbitrary inputs, toggling `CLK`.
  - Required: all leaves stay 0.
  - Assert `nRST` asynchronously between edges; outputs must drop at once.
- Inconsistent tree:
  - Inputs: nodes 0x01A, 0x11C, 0x222, 0x32B, 0x43D, 0x544, 0x1F77.
  - Sums 54 and 77 match no node, so the fallback applies.
  - Required: one edge after release, A=0x01A, B=0x11C, C=0x222, D=0x32B.
- Valid tree, I0 at node4:
  - Weights 5, 7, 9, 12, 21, 25, 46; records 0x005, 0x107, 0x209, 0x30C, 0x415, 0x519, 0x1F2E.
  - I0 = node4, I1 = node5.
  - Required: A=0x005, B=0x107, C=0x209, D=0x519.
- Valid tree, I0 at node3:
  - Weights 2, 3, 5, 6, 10, 11, 21; records 0x002, 0x103, 0x205, 0x306, 0x40A, 0x50B, 0x1F15.
  - I0 = node3, I1 = node6.
  - Required: A=0x002, B=0x103, C=0x306, D=0x40A.
- Overflow:
  - w1=200, w2=100, so S0=300. Node3 weight is 44, which equals 300 mod 256.
  - Required: no match, fallback output (nodes 1–4).
- Back-to-back:
  - Alternate the tree from the third scenario and the tree from the fourth scenario every cycle.
  - Required: outputs alternate correspondingly, each one cycle after its input.
